// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared data-memory geometry and the store-buffer entry type
package cpu_mem_pkg;
  localparam int DM_WORDS = 1024;
  localparam int DM_AW = 10;
  localparam int WA_LO = 2;
  localparam int WA_HI = 11;
  typedef struct packed {
    logic [DM_AW-1:0] addr;
    logic [31:0]      data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: datapath-side and memory-side signals of the store buffer
interface store_buffer_if;
  logic [31:0] alu_out;
  logic [31:0] out2;
  logic        MemWrite;
  logic        MemRead;
  logic        drain_en;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;
  logic [31:0] load_data;
  logic        stall;
  logic        empty;
  modport master (
    output alu_out, out2, MemWrite, MemRead, drain_en, dm_rdata,
    input  dm_addr, dm_wdata, dm_we, load_data, stall, empty
  );
  modport slave (
    input  alu_out, out2, MemWrite, MemRead, drain_en, dm_rdata,
    output dm_addr, dm_wdata, dm_we, load_data, stall, empty
  );
endinterface

// File: rtl/store_buffer_fifo.sv
// sb_fifo: circular store queue exposing every entry oldest-first with a valid mask
module sb_fifo
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  sb_entry_t wr_entry,
  output sb_entry_t entries [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  sb_entry_t     mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wr_entry;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // index 0 is the oldest entry, so higher indices are younger
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign entries[i] = mem[head + PW'(i)];
    assign valid[i]   = CW'(i) < count;
  end
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer owning the data-memory port, with load forwarding
module store_buffer
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = DM_AW
) (
  input logic           clock,
  input logic           reset,
  store_buffer_if.slave bus
);
  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             full, empty_q, pop, push, hit, unused_bits;
  logic [AW-1:0]    waddr;
  logic [31:0]      fwd;
  assign waddr       = bus.alu_out[WA_LO+AW-1:WA_LO];
  assign unused_bits = ^{bus.alu_out[31:WA_LO+AW], bus.alu_out[WA_LO-1:0]};
  assign pop         = bus.drain_en & ~bus.MemRead & ~empty_q;
  assign bus.stall   = bus.MemWrite & full & ~pop;
  assign push        = bus.MemWrite & ~bus.stall;
  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wr_entry ('{addr: waddr, data: bus.out2}),
    .entries  (entries),
    .valid    (valid),
    .full     (full),
    .empty    (empty_q)
  );
  // loads always own the port; otherwise it carries the oldest pending store
  assign bus.dm_we     = pop;
  assign bus.dm_addr   = 32'({bus.MemRead ? waddr : entries[0].addr, 2'b00});
  assign bus.dm_wdata  = entries[0].data;
  assign bus.empty     = empty_q;
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit = (valid[k] && entries[k].addr == waddr) ? 1'b1 : hit;
      fwd = (valid[k] && entries[k].addr == waddr) ? entries[k].data : fwd;
    end
  end
  assign bus.load_data = (bus.MemRead && hit) ? fwd : bus.dm_rdata;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus against a queue-based reference model
module tb_store_buffer;
  import cpu_mem_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } ent_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  store_buffer_if bus ();
  store_buffer #(.DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));
  function automatic logic [31:0] init_val(int a);
    return 32'(a) * 32'h9E3779B1 + 32'h1234;
  endfunction
  // data memory holds a delta against a per-address pattern, so it starts non-trivial
  bit [31:0] delta [DM_WORDS];
  assign bus.dm_rdata = delta[bus.dm_addr[11:2]] ^ init_val(int'(bus.dm_addr[11:2]));
  always @(posedge clock)
    if (bus.dm_we) delta[bus.dm_addr[11:2]] <= bus.dm_wdata ^ init_val(int'(bus.dm_addr[11:2]));
  int errors = 0;
  int checks = 0;
  logic [31:0] mem_ref [DM_WORDS];
  ent_t q[$];
  logic e_pop = 1'b0;
  logic e_push = 1'b0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set_in(bit wr, bit rd, bit dr, logic [31:0] a, logic [31:0] d);
    bus.MemWrite = wr;
    bus.MemRead  = rd;
    bus.drain_en = dr;
    bus.alu_out  = a;
    bus.out2     = d;
  endtask
  task automatic check_model();
    int cnt;
    logic [9:0] wa;
    logic [31:0] ld;
    #1;
    cnt = q.size();
    wa = bus.alu_out[11:2];
    e_pop = bus.drain_en && !bus.MemRead && cnt != 0;
    e_push = bus.MemWrite && !(cnt == DEPTH && !e_pop);
    chk("stall", 32'(bus.stall), 32'(bus.MemWrite && !e_push));
    chk("empty", 32'(bus.empty), 32'(cnt == 0));
    chk("dm_we", 32'(bus.dm_we), 32'(e_pop));
    if (e_pop) begin
      chk("drain_addr", bus.dm_addr, {20'b0, q[0].a, 2'b00});
      chk("drain_data", bus.dm_wdata, q[0].d);
    end
    if (bus.MemRead) begin
      ld = mem_ref[wa];
      foreach (q[i]) if (q[i].a == wa) ld = q[i].d;
      chk("load_addr", bus.dm_addr, {20'b0, wa, 2'b00});
      chk("load_data", bus.load_data, ld);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    if (e_pop) begin
      mem_ref[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (e_push) q.push_back('{bus.alu_out[11:2], bus.out2});
    #1;
  endtask
  task automatic step(bit wr, bit rd, bit dr, logic [31:0] a, logic [31:0] d);
    set_in(wr, rd, dr, a, d);
    check_model();
    tick();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    e_pop = 1'b0;
    e_push = 1'b0;
  endtask
  initial begin
    int r;
    logic [31:0] a;
    for (int i = 0; i < DM_WORDS; i++) mem_ref[i] = init_val(i);
    set_in(0, 0, 0, 0, 0);
    @(posedge clock);
    do_reset();
    // single store, then it drains on the next cycle
    step(1, 0, 0, 32'h010, 32'hDEADBEEF);
    set_in(0, 0, 1, 0, 0);
    check_model();
    chk("s1_we", 32'(bus.dm_we), 32'd1);
    chk("s1_addr", bus.dm_addr, 32'h010);
    chk("s1_data", bus.dm_wdata, 32'hDEADBEEF);
    tick();
    step(0, 0, 0, 0, 0);
    // forwarding while the drain is held off
    step(1, 0, 0, 32'h010, 32'hDEADBEEF);
    set_in(0, 1, 0, 32'h010, 0);
    check_model();
    chk("s2_fwd", bus.load_data, 32'hDEADBEEF);
    chk("s2_we", 32'(bus.dm_we), 32'd0);
    tick();
    step(0, 0, 1, 0, 0);
    // fill to DEPTH, stall the fifth store, then pop and push together
    for (int k = 0; k < DEPTH; k++) step(1, 0, 0, 32'(k * 4), 32'hA000 + 32'(k));
    set_in(1, 0, 0, 32'h100, 32'h55);
    check_model();
    chk("s3_stall", 32'(bus.stall), 32'd1);
    tick();
    set_in(1, 0, 1, 32'h100, 32'h55);
    check_model();
    chk("s3_nostall", 32'(bus.stall), 32'd0);
    chk("s3_pop_addr", bus.dm_addr, 32'h000);
    tick();
    for (int k = 0; k < DEPTH + 1; k++) step(0, 0, 1, 0, 0);
    // write-after-write to the same word
    step(1, 0, 0, 32'h020, 32'h1);
    step(1, 0, 0, 32'h020, 32'h2);
    set_in(0, 1, 0, 32'h020, 0);
    check_model();
    chk("s4_fwd", bus.load_data, 32'h2);
    tick();
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0);
    set_in(0, 1, 0, 32'h020, 0);
    check_model();
    chk("s4_mem", bus.load_data, 32'h2);
    tick();
    // unbuffered load wins the port over a pending drain
    step(1, 0, 0, 32'h040, 32'h40);
    step(1, 0, 0, 32'h044, 32'h44);
    set_in(0, 1, 1, 32'h300, 0);
    check_model();
    chk("s5_addr", bus.dm_addr, 32'h300);
    chk("s5_we", 32'(bus.dm_we), 32'd0);
    chk("s5_rdata", bus.load_data, init_val(32'h300 >> 2));
    tick();
    step(0, 0, 0, 0, 0);
    // reset discards pending stores
    step(1, 0, 0, 32'h048, 32'h48);
    do_reset();
    set_in(0, 0, 1, 0, 0);
    check_model();
    chk("s6_empty", 32'(bus.empty), 32'd1);
    chk("s6_we", 32'(bus.dm_we), 32'd0);
    tick();
    set_in(0, 1, 0, 32'h040, 0);
    check_model();
    chk("s6_rdata", bus.load_data, init_val(32'h040 >> 2));
    tick();
    // random traffic over a few words, with junk in the ignored address bits
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      a = ($urandom() & 32'hFFFFF003) | {20'b0, 7'b0, 3'($urandom_range(0, 7)), 2'b00};
      if (r < 2) do_reset();
      else step(r < 48 || r >= 97, r >= 48, $urandom_range(0, 2) != 0, a, $urandom());
    end
    for (int k = 0; k < DEPTH + 2; k++) step(0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, 0, 32'(k * 4), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
